// File: rtl/bcd_to_byte_pkg.sv
// bcd_to_byte_pkg: shared BCD constants, FSM state encoding and digit helper
package bcd_to_byte_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB = 4'd3;
  typedef enum logic {ST_IDLE, ST_CONV} state_t;
  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX_DIGIT;
  endfunction
endpackage

// File: rtl/bcd_to_byte_if.sv
// bcd_to_byte_if: start/done handshake and result bus of the BCD-to-binary converter
interface bcd_to_byte_if #(parameter int DIGITS = 3, parameter int OUT_W = 8);
  logic start;
  logic [4*DIGITS-1:0] bcd_in;
  logic busy;
  logic done;
  logic [OUT_W-1:0] byte_out;
  logic overflow;
  logic invalid;
  modport master (output start, bcd_in, input busy, done, byte_out, overflow, invalid);
  modport slave (input start, bcd_in, output busy, done, byte_out, overflow, invalid);
endinterface

// File: rtl/bcd_to_byte_digit_adjust.sv
// bcd_digit_adjust: subtract 3 from a BCD digit that is 8 or more after a right shift
module bcd_digit_adjust
  import bcd_to_byte_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = din >= BCD_ADJ_THRESH ? din - BCD_ADJ_SUB : din;
endmodule

// File: rtl/bcd_to_byte.sv
// bcd_to_byte: sequential packed-BCD to binary converter (reverse double-dabble, one shift per clock);
// define BCD_TO_BYTE_SAT_EN to saturate byte_out on overflow instead of truncating
module bcd_to_byte
  import bcd_to_byte_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int OUT_W = 8
) (
  input logic clk,
  input logic rst_n,
  bcd_to_byte_if.slave bus
);
  localparam int ITER = 4 * DIGITS;
  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W = BCD_W + ITER;
  localparam int CNT_W = $clog2(ITER);
`ifdef BCD_TO_BYTE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  state_t state, state_n;
  logic [SR_W-1:0] sr, sr_n, shifted, stepped;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ITER-1:0] bin_final;
  logic [OUT_W-1:0] byte_n;
  logic busy_n, done_n, ovf_n, inv_n, bad, last, accept, ovf_final;
  assign shifted = sr >> 1;
  genvar g;
  for (g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (.din(shifted[ITER+g*4 +: 4]), .dout(stepped[ITER+g*4 +: 4]));
  end
  assign stepped[ITER-1:0] = shifted[ITER-1:0];
  assign bin_final = stepped[ITER-1:0];
  assign ovf_final = |(bin_final >> OUT_W);
  assign last = cnt == CNT_W'(ITER - 1);
  assign accept = state == ST_IDLE && bus.start && !bus.done;
  // flag any input digit above 9
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | digit_bad(bus.bcd_in[i*4 +: 4]);
  end
  // next state, datapath and output values
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    busy_n = bus.busy;
    done_n = 1'b0;
    byte_n = bus.byte_out;
    ovf_n = bus.overflow;
    inv_n = bus.invalid;
    if (accept) begin
      sr_n = {bus.bcd_in, ITER'(0)};
      cnt_n = '0;
      byte_n = '0;
      ovf_n = 1'b0;
      inv_n = bad;
      done_n = bad;
      busy_n = !bad;
      state_n = bad ? ST_IDLE : ST_CONV;
    end else if (state == ST_CONV) begin
      sr_n = stepped;
      cnt_n = cnt + 1'b1;
      if (last) begin
        state_n = ST_IDLE;
        cnt_n = '0;
        busy_n = 1'b0;
        done_n = 1'b1;
        ovf_n = ovf_final;
        byte_n = (SAT && ovf_final) ? {OUT_W{1'b1}} : OUT_W'(bin_final);
      end
    end
  end
  // state and output registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      sr <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.byte_out <= '0;
      bus.overflow <= 1'b0;
      bus.invalid <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      bus.busy <= busy_n;
      bus.done <= done_n;
      bus.byte_out <= byte_n;
      bus.overflow <= ovf_n;
      bus.invalid <= inv_n;
    end
endmodule

// File: tb/tb_bcd_to_byte.sv
// tb_bcd_to_byte: directed self-checking bench for the BCD-to-binary converter
module tb_bcd_to_byte;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int miss = 0;
  bcd_to_byte_if #(.DIGITS(3), .OUT_W(8)) bus ();
  bcd_to_byte #(.DIGITS(3), .OUT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
`ifdef BCD_TO_BYTE_SAT_EN
  localparam logic [7:0] EXP_256 = 8'hFF;
  localparam logic [7:0] EXP_999 = 8'hFF;
`else
  localparam logic [7:0] EXP_256 = 8'h00;
  localparam logic [7:0] EXP_999 = 8'hE7;
`endif
  logic [7:0] b;
  logic o, iv;
  int de, bn, dn;

  task automatic convert(input logic [11:0] bcd, input int inj, output logic [7:0] rb,
                         output logic ro, output logic riv, output int done_edge,
                         output int busy_n, output int dones);
    rb = 'x; ro = 'x; riv = 'x;
    done_edge = -1; busy_n = 0; dones = 0;
    @(negedge clk);
    bus.bcd_in = bcd;
    bus.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.done) begin
        dones++;
        if (done_edge < 0) begin
          done_edge = k - 1;
          rb = bus.byte_out; ro = bus.overflow; riv = bus.invalid;
        end
      end
      if (k == 1) bus.start = 1'b0;
      if (inj > 0 && k == inj) begin bus.start = 1'b1; bus.bcd_in = 12'h999; end
      if (inj > 0 && k == inj + 1) begin bus.start = 1'b0; bus.bcd_in = 12'h123; end
      if (done_edge >= 0 && inj == 0) break;
    end
    vecs++;
    if (done_edge < 0) begin miss++; $display("FAIL timeout bcd=%h: no done within 20 cycles", bcd); end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.bcd_in = '0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vecs++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vecs++; if (bus.done !== 1'b0) begin miss++; $display("FAIL reset_done got %b want 0", bus.done); end
    vecs++; if (bus.byte_out !== 8'h00) begin miss++; $display("FAIL reset_byte got %h want 00", bus.byte_out); end
    vecs++; if ({bus.overflow, bus.invalid} !== 2'b00) begin miss++; $display("FAIL reset_flags got %b want 00", {bus.overflow, bus.invalid}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    convert(12'h255, 0, b, o, iv, de, bn, dn);
    vecs++; if (b !== 8'hFF) begin miss++; $display("FAIL basic_byte got %h want ff", b); end
    vecs++; if ({o, iv} !== 2'b00) begin miss++; $display("FAIL basic_flags got %b want 00", {o, iv}); end
    vecs++; if (de !== 12) begin miss++; $display("FAIL basic_latency got %0d want 12", de); end
    vecs++; if (bn !== 12) begin miss++; $display("FAIL basic_busy_cycles got %0d want 12", bn); end
    @(negedge clk);
    vecs++; if (bus.done !== 1'b0) begin miss++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    vecs++; if (bus.byte_out !== 8'hFF) begin miss++; $display("FAIL basic_hold got %h want ff", bus.byte_out); end
  endtask

  task automatic test_back_to_back;
    convert(12'h000, 0, b, o, iv, de, bn, dn);
    vecs++; if (b !== 8'h00) begin miss++; $display("FAIL zero_byte got %h want 00", b); end
    vecs++; if (de !== 12) begin miss++; $display("FAIL zero_latency got %0d want 12", de); end
    convert(12'h128, 0, b, o, iv, de, bn, dn);
    vecs++; if (b !== 8'h80) begin miss++; $display("FAIL b2b_byte got %h want 80", b); end
    vecs++; if (de !== 12) begin miss++; $display("FAIL b2b_latency got %0d want 12", de); end
  endtask

  task automatic test_overflow;
    convert(12'h256, 0, b, o, iv, de, bn, dn);
    vecs++; if (o !== 1'b1) begin miss++; $display("FAIL ovf256_flag got %b want 1", o); end
    vecs++; if (b !== EXP_256) begin miss++; $display("FAIL ovf256_byte got %h want %h", b, EXP_256); end
    convert(12'h999, 0, b, o, iv, de, bn, dn);
    vecs++; if (o !== 1'b1) begin miss++; $display("FAIL ovf999_flag got %b want 1", o); end
    vecs++; if (b !== EXP_999) begin miss++; $display("FAIL ovf999_byte got %h want %h", b, EXP_999); end
    vecs++; if (iv !== 1'b0) begin miss++; $display("FAIL ovf999_invalid got %b want 0", iv); end
  endtask

  task automatic test_invalid;
    convert(12'h1A3, 0, b, o, iv, de, bn, dn);
    vecs++; if (de !== 0) begin miss++; $display("FAIL inv_latency got %0d want 0", de); end
    vecs++; if (iv !== 1'b1) begin miss++; $display("FAIL inv_flag got %b want 1", iv); end
    vecs++; if (b !== 8'h00) begin miss++; $display("FAIL inv_byte got %h want 00", b); end
    vecs++; if (o !== 1'b0) begin miss++; $display("FAIL inv_ovf got %b want 0", o); end
    vecs++; if (bn !== 0) begin miss++; $display("FAIL inv_busy got %0d want 0", bn); end
  endtask

  task automatic test_ignore_busy;
    convert(12'h042, 5, b, o, iv, de, bn, dn);
    vecs++; if (dn !== 1) begin miss++; $display("FAIL ign_dones got %0d want 1", dn); end
    vecs++; if (b !== 8'h2A) begin miss++; $display("FAIL ign_byte got %h want 2a", b); end
    vecs++; if (iv !== 1'b0) begin miss++; $display("FAIL ign_invalid got %b want 0", iv); end
    vecs++; if (bn !== 12) begin miss++; $display("FAIL ign_busy got %0d want 12", bn); end
  endtask

  task automatic test_ignore_done_cycle;
    convert(12'h100, 13, b, o, iv, de, bn, dn);
    vecs++; if (b !== 8'h64) begin miss++; $display("FAIL dcyc_byte got %h want 64", b); end
    vecs++; if (bn !== 12) begin miss++; $display("FAIL dcyc_busy got %0d want 12", bn); end
    vecs++; if (dn !== 1) begin miss++; $display("FAIL dcyc_dones got %0d want 1", dn); end
    vecs++; if (bus.byte_out !== 8'h64) begin miss++; $display("FAIL dcyc_hold got %h want 64", bus.byte_out); end
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    @(negedge clk);
    bus.bcd_in = 12'h042; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    vecs++; if (bus.busy !== 1'b1) begin miss++; $display("FAIL rmid_busy_before got %b want 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (bus.busy !== 1'b0) begin miss++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
    vecs++; if ({bus.done, bus.overflow, bus.invalid, bus.byte_out} !== 11'h0) begin
      miss++; $display("FAIL rmid_outputs got %b want 0", {bus.done, bus.overflow, bus.invalid, bus.byte_out});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    vecs++; if (seen !== 0) begin miss++; $display("FAIL rmid_no_done got %0d want 0", seen); end
    convert(12'h128, 0, b, o, iv, de, bn, dn);
    vecs++; if (b !== 8'h80) begin miss++; $display("FAIL rmid_after got %h want 80", b); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_overflow;
    test_invalid;
    test_ignore_busy;
    test_ignore_done_cycle;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
